// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential divider: FSM encoding and
// sign/magnitude conversion on a widest-case (64+1 bit) word.
package div_pkg;

  localparam int MAX_W = 64;
  localparam int EXT_W = MAX_W + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    CALC = ST_CALC,
    DONE = ST_DONE
  } state_t;

  // Callers sign- or zero-extend into EXT_W bits, so MIN of a 64-bit operand
  // still has a representable magnitude.
  function automatic logic [EXT_W-1:0] abs_ext(input logic [EXT_W-1:0] value,
                                               input logic is_signed);
    logic [EXT_W-1:0] res;
    if (is_signed && value[EXT_W-1]) begin
      res = (~value) + {{(EXT_W-1){1'b0}}, 1'b1};
    end else begin
      res = value;
    end
    return res;
  endfunction

  function automatic logic [EXT_W-1:0] neg_if(input logic [EXT_W-1:0] value,
                                              input logic cond);
    logic [EXT_W-1:0] res;
    if (cond) begin
      res = (~value) + {{(EXT_W-1){1'b0}}, 1'b1};
    end else begin
      res = value;
    end
    return res;
  endfunction

endpackage

// File: rtl/div_signfix.sv
// Turns unsigned magnitude results into final quotient/remainder, applying
// sign restoration and the divide-by-zero / MIN/-1 overrides.
module div_signfix
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] q_mag,
  input  logic [WIDTH-1:0] r_mag,
  input  logic [WIDTH-1:0] dividend,
  input  logic             q_neg,
  input  logic             r_neg,
  input  logic             dz,
  input  logic             ov,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  logic [EXT_W-1:0] q_fix_s;
  logic [EXT_W-1:0] r_fix_s;

  // Sign restoration, then special-case overrides take priority.
  always_comb begin
    q_fix_s     = neg_if({{(EXT_W-WIDTH){1'b0}}, q_mag}, q_neg);
    r_fix_s     = neg_if({{(EXT_W-WIDTH){1'b0}}, r_mag}, r_neg);
    div_by_zero = dz;
    overflow    = ov & ~dz;
    if (dz) begin
      quotient  = {WIDTH{1'b1}};
      remainder = dividend;
    end else if (ov) begin
      quotient  = dividend;
      remainder = {WIDTH{1'b0}};
    end else begin
      quotient  = q_fix_s[WIDTH-1:0];
      remainder = r_fix_s[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Radix-2 restoring divider, one quotient bit per cycle, signed or unsigned
// per operation, with valid/ready handshakes on both sides.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t           state_r, state_next_s;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] rem_r, quo_r, den_r, dvd_r;
  logic             q_neg_r, r_neg_r, dz_r, ov_r;
  logic [WIDTH-1:0] quotient_r, remainder_r;
  logic             div_by_zero_r, overflow_r;

  logic             accept_s, last_s, ge_s;
  logic [EXT_W-1:0] a_abs_s, b_abs_s;
  logic [WIDTH:0]   shifted_s, diff_s;
  logic [WIDTH-1:0] rem_next_s, quo_next_s;
  logic [WIDTH-1:0] q_fin_s, r_fin_s;
  logic             dz_fin_s, ov_fin_s;

  assign in_ready    = (state_r == IDLE);
  assign out_valid   = (state_r == DONE);
  assign quotient    = quotient_r;
  assign remainder   = remainder_r;
  assign div_by_zero = div_by_zero_r;
  assign overflow    = overflow_r;

  assign accept_s = in_valid & in_ready;
  assign last_s   = (cnt_r == CNT_W'(0));

  // Operand magnitudes and one restoring trial-subtract step.
  always_comb begin
    a_abs_s = abs_ext({{(EXT_W-WIDTH){in_signed & dividend[WIDTH-1]}}, dividend}, in_signed);
    b_abs_s = abs_ext({{(EXT_W-WIDTH){in_signed & divisor[WIDTH-1]}}, divisor}, in_signed);
    shifted_s = {rem_r, quo_r[WIDTH-1]};
    diff_s    = shifted_s - {1'b0, den_r};
    ge_s      = (shifted_s >= {1'b0, den_r});
    if (ge_s) begin
      rem_next_s = diff_s[WIDTH-1:0];
    end else begin
      rem_next_s = shifted_s[WIDTH-1:0];
    end
    quo_next_s = {quo_r[WIDTH-2:0], ge_s};
  end

  div_signfix #(.WIDTH(WIDTH)) u_signfix (
    .q_mag       (quo_next_s),
    .r_mag       (rem_next_s),
    .dividend    (dvd_r),
    .q_neg       (q_neg_r),
    .r_neg       (r_neg_r),
    .dz          (dz_r),
    .ov          (ov_r),
    .quotient    (q_fin_s),
    .remainder   (r_fin_s),
    .div_by_zero (dz_fin_s),
    .overflow    (ov_fin_s)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; DONE always returns through IDLE so in_valid held
  // across DONE is only accepted once.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) state_next_s = CALC;
        else          state_next_s = IDLE;
      end
      CALC: begin
        if (last_s) state_next_s = DONE;
        else        state_next_s = CALC;
      end
      DONE: begin
        if (out_ready) state_next_s = IDLE;
        else           state_next_s = DONE;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Operand capture, iteration datapath and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r         <= CNT_W'(0);
      rem_r         <= {WIDTH{1'b0}};
      quo_r         <= {WIDTH{1'b0}};
      den_r         <= {WIDTH{1'b0}};
      dvd_r         <= {WIDTH{1'b0}};
      q_neg_r       <= 1'b0;
      r_neg_r       <= 1'b0;
      dz_r          <= 1'b0;
      ov_r          <= 1'b0;
      quotient_r    <= {WIDTH{1'b0}};
      remainder_r   <= {WIDTH{1'b0}};
      div_by_zero_r <= 1'b0;
      overflow_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            cnt_r   <= CNT_W'(WIDTH - 1);
            rem_r   <= {WIDTH{1'b0}};
            quo_r   <= a_abs_s[WIDTH-1:0];
            den_r   <= b_abs_s[WIDTH-1:0];
            dvd_r   <= dividend;
            q_neg_r <= in_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            r_neg_r <= in_signed & dividend[WIDTH-1];
            dz_r    <= (divisor == {WIDTH{1'b0}});
            ov_r    <= in_signed && (dividend == {1'b1, {(WIDTH-1){1'b0}}})
                                 && (divisor == {WIDTH{1'b1}});
          end
        end
        CALC: begin
          rem_r <= rem_next_s;
          quo_r <= quo_next_s;
          if (last_s) begin
            quotient_r    <= q_fin_s;
            remainder_r   <= r_fin_s;
            div_by_zero_r <= dz_fin_s;
            overflow_r    <= ov_fin_s;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: directed corner cases, back-pressure,
// mid-operation reset, then randomized traffic against an arithmetic model.
module tb_seq_divider;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic         in_signed;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  logic         overflow;

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_signed   (in_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a, b;
    logic         s;
    logic [W-1:0] q, r;
    logic         dz, ov;
    int           acc_edge;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  logic        rand_rdy = 1'b0;
  logic        forced_rdy = 1'b1;
  logic [63:0] sig_exp = 64'd0;
  logic [63:0] sig_act = 64'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference: plain integer division with the documented special cases.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_t   e;
    longint sa, sb;
    e.a = a; e.b = b; e.s = s; e.dz = 1'b0; e.ov = 1'b0; e.acc_edge = 0;
    if (b == 32'd0) begin
      e.q = 32'hFFFF_FFFF; e.r = a; e.dz = 1'b1;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.q = a; e.r = 32'd0; e.ov = 1'b1;
    end else if (s) begin
      sa = $signed(a); sb = $signed(b);
      e.q = W'(sa / sb); e.r = W'(sa % sb);
    end else begin
      e.q = a / b; e.r = a % b;
    end
    return e;
  endfunction

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : forced_rdy;
  end

  // Input monitor: an accept happens at the next rising edge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && in_valid && in_ready) begin
      e = model(dividend, divisor, in_signed);
      e.acc_edge = cyc + 1;
      sb_q.push_back(e);
    end
  end

  // Output monitor: latency on the rising out_valid, full compare on transfer.
  logic prev_ov = 1'b0;
  always @(negedge clk) begin
    exp_t   e;
    longint rr, dd;
    if (out_valid && !prev_ov) begin
      chk("op_pending", 64'(sb_q.size() > 0), 64'd1);
      if (sb_q.size() > 0) chk("latency", 64'(cyc - sb_q[0].acc_edge), 64'(W));
    end
    if (out_valid && out_ready && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("quotient", 64'(quotient), 64'(e.q));
      chk("remainder", 64'(remainder), 64'(e.r));
      chk("div_by_zero", 64'(div_by_zero), 64'(e.dz));
      chk("overflow", 64'(overflow), 64'(e.ov));
      if (!e.dz && !e.ov) begin
        chk("q*d+r", 64'(W'(quotient * e.b + remainder)), 64'(e.a));
        rr = e.s ? longint'($signed(remainder)) : longint'(remainder);
        dd = e.s ? longint'($signed(e.b)) : longint'(e.b);
        if (rr < 0) rr = -rr;
        if (dd < 0) dd = -dd;
        chk("rem_lt_div", 64'(rr < dd), 64'd1);
        if (e.s && remainder != 32'd0) chk("rem_sign", 64'(remainder[W-1]), 64'(e.a[W-1]));
        if (e.s && quotient != 32'd0) chk("quo_sign", 64'(quotient[W-1]), 64'(e.a[W-1] ^ e.b[W-1]));
      end
      sig_exp = {sig_exp[62:0], sig_exp[63]} ^ {e.q, e.r} ^ {62'd0, e.dz, e.ov};
      sig_act = {sig_act[62:0], sig_act[63]} ^ {quotient, remainder} ^ {62'd0, div_by_zero, overflow};
    end
    prev_ov = out_valid;
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    int t;
    in_valid = 1'b1; dividend = a; divisor = b; in_signed = s;
    t = 0;
    do begin @(negedge clk); t++; end while (!in_ready && t < 200);
    if (!in_ready) chk("accept_timeout", 64'(in_ready), 64'd1);
    @(posedge clk); #2;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int t;
    t = 0;
    do begin @(negedge clk); t++; end while (!out_valid && t < 200);
    if (!out_valid) chk("valid_timeout", 64'(out_valid), 64'd1);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    do begin @(negedge clk); t++; end while (!in_ready && t < 200);
    if (!in_ready) chk("idle_timeout", 64'(in_ready), 64'd1);
    @(posedge clk); #2;
  endtask

  typedef struct {
    logic [W-1:0] a, b;
    logic         s;
    logic [W-1:0] q, r;
    logic         dz, ov;
  } dir_t;

  dir_t dir_tab[6] = '{
    '{32'hFFFF_FF9C, 32'd7,        1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 1'b0},
    '{32'd100,       32'hFFFF_FFF9, 1'b1, 32'hFFFF_FFF2, 32'd2,        1'b0, 1'b0},
    '{32'h0000_1234, 32'd0,        1'b0, 32'hFFFF_FFFF, 32'h0000_1234, 1'b1, 1'b0},
    '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0,        1'b0, 1'b1},
    '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd1,        32'd0,        1'b0, 1'b0},
    '{32'hFFFF_FFF9, 32'd0,        1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1, 1'b0}
  };

  initial begin
    logic [W-1:0] a, b;
    logic         s;
    int           sel, spur, t;

    rst = 1'b1; in_valid = 1'b0; in_signed = 1'b0;
    dividend = 32'd0; divisor = 32'd0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_q_r_flags", {quotient, remainder} | 64'({div_by_zero, overflow}), 64'd0);
    rst = 1'b0;

    // Unsigned 100/7 with back-pressure and a second operand waiting.
    forced_rdy = 1'b0;
    @(posedge clk); #2;
    issue(32'd100, 32'd7, 1'b0);
    wait_valid();
    in_valid = 1'b1; dividend = 32'd200; divisor = 32'd9; in_signed = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_quotient", 64'(quotient), 64'd14);
      chk("bp_remainder", 64'(remainder), 64'd2);
      chk("bp_flags", 64'({div_by_zero, overflow}), 64'd0);
      chk("bp_in_ready", 64'({out_valid, in_ready}), 64'b10);
    end
    forced_rdy = 1'b1;
    @(posedge clk); #2;
    @(negedge clk);
    chk("bp_still_valid", 64'(out_valid), 64'd1);
    @(posedge clk);
    @(negedge clk);
    chk("bp_idle", 64'({in_ready, out_valid}), 64'b10);
    chk("bp_hold_q", 64'(quotient), 64'd14);
    @(posedge clk);
    @(negedge clk);
    chk("bp_reaccept", 64'(in_ready), 64'd0);
    @(posedge clk); #2;
    in_valid = 1'b0;
    wait_idle();

    // Directed corner cases checked against constants while held in DONE.
    foreach (dir_tab[i]) begin
      forced_rdy = 1'b0;
      @(posedge clk); #2;
      issue(dir_tab[i].a, dir_tab[i].b, dir_tab[i].s);
      wait_valid();
      chk("dir_quotient", 64'(quotient), 64'(dir_tab[i].q));
      chk("dir_remainder", 64'(remainder), 64'(dir_tab[i].r));
      chk("dir_flags", 64'({div_by_zero, overflow}), 64'({dir_tab[i].dz, dir_tab[i].ov}));
      forced_rdy = 1'b1;
      wait_idle();
    end

    // Reset in the middle of a calculation.
    issue(32'd123456, 32'd789, 1'b0);
    repeat (14) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_q_r", {quotient, remainder}, 64'd0);
    chk("mid_rst_flags", 64'({div_by_zero, overflow}), 64'd0);
    sb_q.delete();
    @(posedge clk); #2;
    rst = 1'b0;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    spur = 0;
    repeat (40) begin @(negedge clk); if (out_valid) spur++; end
    chk("post_rst_spurious", 64'(spur), 64'd0);

    // Randomized traffic with random consumer back-pressure.
    rand_rdy = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      s   = 1'($urandom_range(0, 1));
      a   = $urandom;
      sel = $urandom_range(0, 9);
      case (sel)
        0: b = 32'd0;
        1: begin b = 32'hFFFF_FFFF; if (s) a = 32'h8000_0000; end
        2: b = 32'd1;
        3: b = 32'hFFFF_FFFF;
        4: begin a = a >> $urandom_range(0, 31); b = $urandom; end
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      issue(a, b, s);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #2;
    end

    t = 0;
    while (sb_q.size() > 0 && t < 2000) begin @(posedge clk); t++; end
    chk("drain", 64'(sb_q.size()), 64'd0);
    chk("signature", sig_act, sig_exp);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Iterative radix-2 restoring divider; the inverse of the team's combinational signed/unsigned multiplier.
- Accepts a dividend/divisor pair through a valid/ready handshake and computes one quotient bit per cycle.
- Returns quotient and remainder with a valid/ready handshake.
- Supports signed (truncate-toward-zero) and unsigned modes per operation; used by the arithmetic regression alongside the multiplier to check q*d+r == n.

Parameters:
- WIDTH, 32, operand/result width in bits (legal range 2..64).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand pair presented.
- in_ready  output  1  divider idle and able to accept.
- in_signed  input  1  1 = treat operands as two's complement; 0 = unsigned.
- dividend  input  WIDTH  numerator.
- divisor  input  WIDTH  denominator.
- out_valid  output  1  result registers hold a completed result.
- out_ready  input  1  consumer takes result.
- quotient  output  WIDTH  result quotient.
- remainder  output  WIDTH  result remainder; its sign follows the dividend in signed mode.
- div_by_zero  output  1  flag qualified by out_valid.
- overflow  output  1  signed MIN/-1 flag qualified by out_valid.

Behaviour:
- Reset (async, any state): state=IDLE; in_ready=1; out_valid=0; quotient, remainder, div_by_zero, overflow all 0; iteration counter 0.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready, capture operands and mode, go to CALC, counter=WIDTH-1.
  - CALC: in_ready=0. One shift/trial-subtract per cycle. When counter==0, apply sign fix, register outputs, go to DONE; otherwise decrement the counter.
  - DONE: out_valid=1 and outputs held stable. On out_ready, go to IDLE. No new operand is accepted in the same cycle (in_ready=0 in DONE).
- Latency: accepting edge = edge 0; out_valid rises after edge WIDTH. Fixed for every operand, including the special cases.
- Throughput: one op per WIDTH+2 cycles with out_ready held high.
- Signed mode:
  - Divide magnitudes; quotient negated if operand signs differ; remainder negated if dividend is negative.
  - Internal magnitudes are WIDTH+1 bits so MIN is representable.
- Divide by zero (divisor==0, either mode): quotient = all ones, remainder = dividend, div_by_zero=1, overflow=0.
- Signed overflow (in_signed, dividend = 1 followed by zeros, divisor = all ones): quotient = dividend (MIN), remainder = 0, overflow=1.
- Unsigned all-ones/all-ones gives q=1, r=0; no flag.
- Inputs are ignored while not in IDLE. in_valid held across DONE does not double-accept; it is accepted on the first IDLE cycle.
- out_valid is never asserted without a prior accept. Result registers keep their last values after the DONE→IDLE transition.
- Reset asserted mid-CALC or in DONE aborts the operation; no out_valid follows reset release until a new accept.

Decomposition:
- Package div_pkg:
  - state enum {IDLE, CALC, DONE};
  - WIDTH-independent localparams for state encoding;
  - function abs_ext(value, is_signed) returning a WIDTH+1 magnitude;
  - function neg_if(value, cond).
- Sub-module div_signfix (combinational): magnitude results + sign bits + special-case flags → final quotient/remainder/flags. This keeps the FSM/datapath module clean and lets the checker reuse it.

Test Plan:
- Unsigned 100/7 (WIDTH=32) → quotient=14, remainder=2, flags 0; out_valid rises exactly 32 edges after accept.
- Signed -100/7 → quotient=0xFFFFFFF2, remainder=0xFFFFFFFE; signed 100/-7 → quotient=0xFFFFFFF2, remainder=2.
- Unsigned 0x1234/0 → quotient=0xFFFFFFFF, remainder=0x1234, div_by_zero=1; signed 0x80000000/0xFFFFFFFF → quotient=0x80000000, remainder=0, overflow=1.
- Back-pressure: hold out_ready=0 for 10 cycles in DONE → outputs stable, in_ready=0, no second accept. Release → IDLE one edge later. With in_valid held, the next op is accepted on the following edge.
- Reset pulse at CALC cycle 15 → out_valid, quotient, remainder and flags read 0 immediately (async). in_ready=1 after release. No spurious out_valid over the next 40 cycles.
- LFSR-driven 1000 random ops, both modes, out_ready randomly toggled; for non-special cases, check:
  - dividend == quotient*divisor + remainder (mod 2^WIDTH);
  - |remainder| < |divisor|;
  - sign rules above;
  - fold results into a 64-bit signature compared against a golden value.
